// File: rtl/turn_scheduler.sv
// Round sequencer: initial deal, one-hot player turns with HIT/STAND handling, dealer hand-off.
// Optional per-turn idle timeout enabled by defining TURN_TIMEOUT_EN.
`ifndef gameCommand
`define gameCommand logic [1:0]
`endif
`ifndef COMMAND_NONE
`define COMMAND_NONE 2'd0
`endif
`ifndef COMMAND_HIT
`define COMMAND_HIT 2'd1
`endif
`ifndef COMMAND_STAND
`define COMMAND_STAND 2'd2
`endif

module turn_scheduler #(
  parameter int NUM_PLAYERS    = 2,
  parameter int MAX_CARDS      = 5,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_round_start,
  input  logic                               i_ready,
  input  `gameCommand                        i_command,
  input  logic [NUM_PLAYERS-1:0]             i_bust,
  input  logic                               i_deal_ack,
  input  logic                               i_dealer_done,
  output logic [NUM_PLAYERS-1:0]             o_turn,
  output logic                               o_deal_req,
  output logic [$clog2(NUM_PLAYERS+1)-1:0]   o_deal_target,
  output logic                               o_dealer_turn,
  output logic                               o_round_done
);

  localparam int TW = $clog2(NUM_PLAYERS + 1);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW = $clog2(MAX_CARDS + 1);
  localparam logic [TW-1:0] DEALER_TARGET = TW'(NUM_PLAYERS);
  localparam logic [PW-1:0] LAST_PLAYER   = PW'(NUM_PLAYERS - 1);
  localparam logic [CW-1:0] CARD_LIMIT    = CW'(MAX_CARDS);

  typedef enum logic [3:0] {
    IDLE, INIT_DEAL, PLAY, DEAL_HIT, RELEASE, RELEASE_ADV, ADVANCE, DEALER, DONE
  } stateType;

  stateType        state_q, state_d;
  logic [PW-1:0]   player_q, player_d;
  logic [TW-1:0]   dealTarget_q, dealTarget_d;
  logic            dealReq_q, dealReq_d;
  logic            secondPass_q, secondPass_d;
  logic            readyPrev_q;
  logic [CW-1:0]   cardCount_q [NUM_PLAYERS];
  logic [CW-1:0]   cardCount_d [NUM_PLAYERS];
  logic            readyEdge;
  logic            turnOver;

`ifdef TURN_TIMEOUT_EN
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  logic [OW-1:0]   idleCount_q, idleCount_d;
`else
  logic            unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES == 0);
`endif

  // readyPrev tracks i_ready every cycle, so a button held across a turn change never looks like a press
  assign readyEdge = i_ready && !readyPrev_q;
  assign turnOver  = i_bust[player_q] || (cardCount_q[player_q] == CARD_LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      player_q     <= '0;
      dealTarget_q <= '0;
      dealReq_q    <= 1'b0;
      secondPass_q <= 1'b0;
      readyPrev_q  <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) cardCount_q[p] <= '0;
`ifdef TURN_TIMEOUT_EN
      idleCount_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      player_q     <= player_d;
      dealTarget_q <= dealTarget_d;
      dealReq_q    <= dealReq_d;
      secondPass_q <= secondPass_d;
      readyPrev_q  <= i_ready;
      cardCount_q  <= cardCount_d;
`ifdef TURN_TIMEOUT_EN
      idleCount_q  <= idleCount_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    dealTarget_d = dealTarget_q;
    dealReq_d    = dealReq_q;
    secondPass_d = secondPass_q;
    cardCount_d  = cardCount_q;
`ifdef TURN_TIMEOUT_EN
    idleCount_d  = '0;
`endif
    o_turn        = '0;
    o_deal_req    = dealReq_q;
    o_deal_target = dealTarget_q;
    o_dealer_turn = (state_q == DEALER);
    o_round_done  = (state_q == DONE);

    if (state_q == PLAY || state_q == DEAL_HIT || state_q == RELEASE || state_q == RELEASE_ADV) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (PW'(p) == player_q) o_turn[p] = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (i_round_start) begin
          state_d      = INIT_DEAL;
          dealTarget_d = '0;
          secondPass_d = 1'b0;
          dealReq_d    = 1'b0;
          for (int p = 0; p < NUM_PLAYERS; p++) cardCount_d[p] = '0;
        end
      end
      // Request is raised one cycle after the previous ack, giving the mandatory idle gap
      INIT_DEAL: begin
        if (!dealReq_q) begin
          dealReq_d = 1'b1;
        end else if (i_deal_ack) begin
          dealReq_d = 1'b0;
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (TW'(p) == dealTarget_q && cardCount_q[p] != CARD_LIMIT)
              cardCount_d[p] = cardCount_q[p] + 1'b1;
          end
          if (dealTarget_q == DEALER_TARGET) begin
            dealTarget_d = '0;
            if (secondPass_q) begin
              state_d  = PLAY;
              player_d = '0;
            end else begin
              secondPass_d = 1'b1;
            end
          end else begin
            dealTarget_d = dealTarget_q + 1'b1;
          end
        end
      end
      PLAY: begin
`ifdef TURN_TIMEOUT_EN
        idleCount_d = idleCount_q + 1'b1;
`endif
        if (turnOver) begin
          state_d = ADVANCE;
        end else if (readyEdge && i_command == `COMMAND_HIT) begin
          state_d      = DEAL_HIT;
          dealTarget_d = TW'(player_q);
`ifdef TURN_TIMEOUT_EN
          idleCount_d  = '0;
`endif
        end else if (readyEdge && i_command == `COMMAND_STAND) begin
          state_d = RELEASE_ADV;
`ifdef TURN_TIMEOUT_EN
          idleCount_d = '0;
        end else if (idleCount_q == OW'(TIMEOUT_CYCLES - 1)) begin
          state_d = RELEASE_ADV;
`endif
        end
      end
      DEAL_HIT: begin
        if (!dealReq_q) begin
          dealReq_d = 1'b1;
        end else if (i_deal_ack) begin
          dealReq_d = 1'b0;
          state_d   = RELEASE;
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (PW'(p) == player_q && cardCount_q[p] != CARD_LIMIT)
              cardCount_d[p] = cardCount_q[p] + 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!i_ready) state_d = PLAY;
      end
      RELEASE_ADV: begin
        if (!i_ready) state_d = ADVANCE;
      end
      ADVANCE: begin
        if (player_q == LAST_PLAYER) begin
          state_d = DEALER;
        end else begin
          player_d = player_q + 1'b1;
          state_d  = PLAY;
        end
      end
      DEALER: begin
        if (i_dealer_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
